// File: rtl/ordering_queue.sv
// ---------------------------------------------------------------------------
// ordering_queue
//
// In-order request queue with an outstanding-transaction tracker. Requests are
// pushed at the tail. Only the head can issue, and only once it is
// eligible:
//   - fewer than MAX_OUT transactions are outstanding,
//   - its ID is not already outstanding,
//   - and, for an ordered (fence) request, nothing at all is outstanding.
// Issued IDs stay outstanding until a retire strobe names them. A retire
// for an ID that is not outstanding sets a sticky error flag.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   rx_valid_i/rx_ready_o      request handshake (ID, payload, order flag)
//   rx_id_i, rx_payload_i      request ID and payload
//   rx_order_i                 request is ordered (forced to 1 when STRICT)
//   rx_ret_i, rx_ret_id_i      retire strobe and ID, one per cycle
//   tx_valid_o/tx_ready_i      issue handshake for the head entry
//   tx_id_o, tx_payload_o      head fields; zero when the queue is empty
//   out_cnt_o                  number of outstanding transactions
//   ret_err_o                  sticky flag: retire of a non-outstanding ID
// ---------------------------------------------------------------------------
module ordering_queue #(
   parameter int ID_W    = 3,
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 8,
   parameter bit STRICT  = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rx_valid_i,
   input  logic [ID_W-1:0]              rx_id_i,
   input  logic [DATA_W-1:0]            rx_payload_i,
   input  logic                         rx_order_i,
   output logic                         rx_ready_o,
   input  logic                         rx_ret_i,
   input  logic [ID_W-1:0]              rx_ret_id_i,
   output logic                         tx_valid_o,
   output logic [ID_W-1:0]              tx_id_o,
   output logic [DATA_W-1:0]            tx_payload_o,
   input  logic                         tx_ready_i,
   output logic [$clog2(MAX_OUT+1)-1:0] out_cnt_o,
   output logic                         ret_err_o
);

   localparam int PW  = $clog2(DEPTH);
   localparam int OW  = PW + 1;
   localparam int CW  = $clog2(MAX_OUT + 1);
   localparam int NID = 1 << ID_W;

   localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] payload;
      logic              ord;
   } entry_t;

   // Queue storage carries no reset; everything read from it is gated by
   // the registered occupancy.
   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [OW-1:0]   occ;

   // Outstanding tracker: one bit per ID plus a running count.
   logic [NID-1:0]  busy;
   logic [NID-1:0]  busy_nxt;
   logic [CW-1:0]   out_cnt;
   logic [CW-1:0]   out_cnt_nxt;
   logic            ret_err;

   entry_t          head;
   logic            empty;
   logic            cap_ok;
   logic            order_ok;
   logic            push;
   logic            pop;
   logic            ret_hit;
   logic            ret_miss;

   // ------------------------------------------------------------------
   // Head view and eligibility: registered state only, so neither
   // rx_ready_o nor tx_valid_o has a combinational path from an input.
   // A same-cycle retire therefore only helps on the following cycle.
   // ------------------------------------------------------------------
   assign head     = mem[rd_ptr];
   assign empty    = (occ == '0);
   assign cap_ok   = (out_cnt < MAX_OUT_C);
   assign order_ok = !head.ord || (out_cnt == '0);

   assign rx_ready_o   = (occ != OCC_FULL);
   assign tx_valid_o   = !empty && cap_ok && !busy[head.id] && order_ok;
   assign tx_id_o      = empty ? '0 : head.id;
   assign tx_payload_o = empty ? '0 : head.payload;
   assign out_cnt_o    = out_cnt;
   assign ret_err_o    = ret_err;

   // A full queue never accepts, even when the head pops in the same cycle.
   assign push     = rx_valid_i && rx_ready_o;
   assign pop      = tx_valid_o && tx_ready_i;
   // A retire for an ID issued in this same cycle sees its bit still clear
   // and is therefore an error.
   assign ret_hit  = rx_ret_i &&  busy[rx_ret_id_i];
   assign ret_miss = rx_ret_i && !busy[rx_ret_id_i];

   // Issue and a valid retire can never name the same ID in one cycle:
   // issue needs the bit clear and the retire needs it set.
   always_comb begin
      busy_nxt = busy;
      if (ret_hit) busy_nxt[rx_ret_id_i] = 1'b0;
      if (pop)     busy_nxt[head.id]     = 1'b1;
   end

   always_comb begin
      out_cnt_nxt = out_cnt;
      if (pop && !ret_hit)      out_cnt_nxt = out_cnt + CW'(1);
      else if (!pop && ret_hit) out_cnt_nxt = out_cnt - CW'(1);
   end

   // ------------------------------------------------------------------
   // Storage write
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{id: rx_id_i, payload: rx_payload_i, ord: rx_order_i | STRICT};
      end
   end

   // ------------------------------------------------------------------
   // Pointers and occupancy; pointers wrap naturally (DEPTH = 2**PW)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outstanding tracker and sticky retire error
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy    <= '0;
         out_cnt <= '0;
         ret_err <= 1'b0;
      end else begin
         busy    <= busy_nxt;
         out_cnt <= out_cnt_nxt;
         if (ret_miss) ret_err <= 1'b1;
      end
   end

endmodule
